// File: rtl/okim6295_pkg.sv
// Shared types and constants for the OKIM6295 sample-ROM responder.
// The line buffer holds one 8-byte line, which is refilled by one 4-word burst.
package okim6295_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL
   } state_e;

   localparam int BURST_LEN  = 4;
   localparam int LINE_BYTES = 8;

   function automatic logic [14:0] lineOf(input logic [17:0] addr);
      return addr[17:3];
   endfunction

endpackage

// File: rtl/okim6295_rom_server.sv
// Serves byte reads for the ADPCM core from a single 8-byte line buffer and
// refills that line with a 4-word little-endian burst from the sound-ROM port.
module okim6295_rom_server
   import okim6295_pkg::*;
#(
   parameter int                        MEM_ADDR_WIDTH = 25,
   parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [17:0]               io_rom_addr,
   output logic [7:0]                io_rom_dout,
   output logic                      io_rom_valid,
   output logic                      io_mem_rd,
   output logic [MEM_ADDR_WIDTH-1:0] io_mem_addr,
   input  logic                      io_mem_waitReq,
   input  logic                      io_mem_valid,
   input  logic [15:0]               io_mem_dout
);

   state_e      state_q, state_d;
   logic [14:0] tag_q, tag_d;
   logic [14:0] req_line_q, req_line_d;
   logic        line_valid_q, line_valid_d;
   logic [1:0]  word_cnt_q, word_cnt_d;
   logic [15:0] line_q [BURST_LEN];
   logic [15:0] line_d [BURST_LEN];
   logic        hit;
   logic [15:0] sel_word;

   // Handshake: a burst request is taken in the cycle where io_mem_rd=1 and
   // io_mem_waitReq=0; rd and addr are held stable until then. Each cycle with
   // io_mem_valid=1 in FILL delivers one word; words outside FILL are dropped.
   assign hit          = line_valid_q && (tag_q == lineOf(io_rom_addr)) && (state_q == IDLE);
   assign io_rom_valid = hit && !reset;
   assign sel_word     = line_q[io_rom_addr[2:1]];
   assign io_rom_dout  = io_rom_addr[0] ? sel_word[15:8] : sel_word[7:0];
   assign io_mem_rd    = (state_q == REQ) && !reset;
   assign io_mem_addr  = BASE_ADDR
                       + (MEM_ADDR_WIDTH'(req_line_q) * MEM_ADDR_WIDTH'(LINE_BYTES));

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      req_line_d   = req_line_q;
      line_valid_d = line_valid_q;
      word_cnt_d   = word_cnt_q;
      line_d       = line_q;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               req_line_d   = lineOf(io_rom_addr);
               line_valid_d = 1'b0;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (!io_mem_waitReq) begin
               word_cnt_d = 2'd0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (io_mem_valid) begin
               line_d[word_cnt_q] = io_mem_dout;
               word_cnt_d         = word_cnt_q + 2'd1;
               // The line is tagged with the requested line even if the
               // address moved meanwhile; IDLE re-checks and may refetch.
               if (word_cnt_q == 2'(BURST_LEN - 1)) begin
                  tag_d        = req_line_q;
                  line_valid_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         tag_q        <= '0;
         req_line_q   <= '0;
         line_valid_q <= 1'b0;
         word_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         req_line_q   <= req_line_d;
         line_valid_q <= line_valid_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      line_q <= line_d;
   end

endmodule

// File: tb/tb_okim6295_rom_server.sv
// Bench for okim6295_rom_server: a burst memory model, a byte-level ROM
// reference, and a scoreboard that checks every valid ROM byte.
module tb_okim6295_rom_server;

   localparam int             AW   = 25;
   localparam logic [AW-1:0]  BASE = 25'h0100000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [17:0]   io_rom_addr = 18'h00005;
   logic [7:0]    io_rom_dout;
   logic          io_rom_valid;
   logic          io_mem_rd;
   logic [AW-1:0] io_mem_addr;
   logic          io_mem_waitReq;
   logic          io_mem_valid;
   logic [15:0]   io_mem_dout;

   always #5 clock = ~clock;

   okim6295_rom_server #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset),
      .io_rom_addr(io_rom_addr), .io_rom_dout(io_rom_dout), .io_rom_valid(io_rom_valid),
      .io_mem_rd(io_mem_rd), .io_mem_addr(io_mem_addr), .io_mem_waitReq(io_mem_waitReq),
      .io_mem_valid(io_mem_valid), .io_mem_dout(io_mem_dout)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    exp_q[$];
   logic [AW-1:0] burst_q[$];

   int            stall_left = 0;
   int            mem_lat    = 2;
   int            mem_gap    = 0;
   int            beats_left = 0;
   int            beats_sent = 0;
   int            accepts    = 0;
   int            mem_delay  = 0;
   logic          corrupt    = 1'b0;
   logic          prev_rd    = 1'b0;
   logic [AW-1:0] seen_addr  = '0;
   logic [15:0]   words [4];

   logic          model_valid = 1'b0;
   logic [14:0]   model_line  = '0;

   // ROM contents: line 0 holds 0x00,0x11,..,0x77; other lines are scrambled.
   function automatic logic [7:0] rom_byte(input logic [17:0] a);
      logic [7:0] h;
      h = 8'(a[17:3] * 15'd37);
      return {1'b0, a[2:0], 1'b0, a[2:0]} ^ h;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting, required event within budget", name);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Memory model: accepts bursts, stalls on demand, returns 4 words.
   initial begin
      logic [17:0] off;
      io_mem_waitReq = 1'b0;
      io_mem_valid   = 1'b0;
      io_mem_dout    = '0;
      forever begin
         step();
         io_mem_valid = 1'b0;
         if (beats_left > 0) begin
            if (mem_delay > 0) begin
               mem_delay--;
            end else begin
               io_mem_valid = 1'b1;
               io_mem_dout  = corrupt ? ~words[4 - beats_left] : words[4 - beats_left];
               beats_left--;
               beats_sent++;
               mem_delay = mem_gap;
            end
         end
         io_mem_waitReq = 1'b0;
         if (io_mem_rd) begin
            if (!prev_rd) seen_addr = io_mem_addr;
            else check("req_addr_stable", 32'(io_mem_addr), 32'(seen_addr));
            if (stall_left > 0 || beats_left > 0) begin
               io_mem_waitReq = 1'b1;
               if (stall_left > 0) stall_left--;
            end else begin
               if (burst_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_burst: got addr %0h, required no request", io_mem_addr);
               end else begin
                  check("burst_addr", 32'(io_mem_addr), 32'(burst_q.pop_front()));
               end
               off = 18'(io_mem_addr - BASE);
               for (int i = 0; i < 4; i++)
                  words[i] = {rom_byte(18'(off + 18'(2 * i + 1))), rom_byte(18'(off + 18'(2 * i)))};
               corrupt    = 1'b0;
               beats_left = 4;
               beats_sent = 0;
               mem_delay  = mem_lat - 1;
               accepts++;
            end
         end
         prev_rd = io_mem_rd && io_mem_waitReq;
      end
   end

   // Scoreboard monitor: every valid presentation with a pending expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && io_rom_valid && exp_q.size() > 0)
            check("rom_dout", 32'(io_rom_dout), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_valid(output int lat);
      lat = 0;
      @(negedge clock);
      while (!io_rom_valid && lat < 300) begin
         lat++;
         @(negedge clock);
      end
      if (!io_rom_valid) timeout("rom_valid");
   endtask

   task automatic issue(input logic [17:0] a, output int lat);
      step();
      io_rom_addr = a;
      exp_q.push_back(rom_byte(a));
      if (!(model_valid && model_line == a[17:3]))
         burst_q.push_back(BASE + AW'({a[17:3], 3'b000}));
      model_valid = 1'b1;
      model_line  = a[17:3];
      wait_valid(lat);
   endtask

   task automatic wait_beats(input int acc_target, input int beats);
      int budget = 0;
      while (!(accepts >= acc_target && beats_sent >= beats) && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      if (budget >= 200) timeout("burst_progress");
   endtask

   initial begin
      int          lat;
      int          acc0;
      int          s;
      logic [17:0] a;
      logic        exp_hit;

      // Cold miss out of reset at address 5.
      exp_q.push_back(8'h55);
      burst_q.push_back(BASE);
      model_valid = 1'b1;
      model_line  = '0;
      repeat (2) step();
      @(negedge clock);
      check("reset_rom_valid", 32'(io_rom_valid), 0);
      check("reset_mem_rd", 32'(io_mem_rd), 0);
      check("reset_mem_addr", 32'(io_mem_addr), 32'(BASE));
      step();
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_rom_valid", 32'(io_rom_valid), 0);
      check("post_reset_mem_rd", 32'(io_mem_rd), 0);
      lat = 1;
      while (!io_rom_valid && lat < 300) begin
         @(negedge clock);
         if (!io_rom_valid) lat++;
      end
      check("cold_miss_latency", 32'(lat), 7);

      // Hits across the whole line, no memory traffic.
      acc0 = accepts;
      for (int i = 0; i < 8; i++) begin
         issue(18'(i), lat);
         check("hit_latency", 32'(lat), 0);
      end
      check("hits_no_burst", 32'(accepts - acc0), 0);

      // Line crossing 7 -> 8.
      issue(18'h00008, lat);
      check("line_cross_latency", 32'(lat), 7);

      // Stall in REQ for 5 cycles.
      acc0       = accepts;
      stall_left = 5;
      issue(18'h00123, lat);
      check("stall_latency", 32'(lat), 12);
      check("stall_one_accept", 32'(accepts - acc0), 1);

      // Retarget while the first burst is mid-fill.
      mem_gap = 2;
      acc0    = accepts;
      step();
      io_rom_addr = 18'h00010;
      burst_q.push_back(BASE + AW'(18'h00010));
      wait_beats(acc0 + 1, 2);
      step();
      io_rom_addr = 18'h3FFF8;
      exp_q.push_back(rom_byte(18'h3FFF8));
      burst_q.push_back(BASE + AW'(18'h3FFF8));
      model_line = 15'h7FFF;
      wait_valid(lat);
      check("retarget_two_bursts", 32'(accepts - acc0), 2);

      // Reset in FILL after two words; leftover beats arrive corrupted.
      mem_gap = 1;
      acc0    = accepts;
      step();
      io_rom_addr = 18'h00021;
      burst_q.push_back(BASE + AW'(18'h00020));
      wait_beats(acc0 + 1, 2);
      step();
      reset   = 1'b1;
      corrupt = 1'b1;
      @(negedge clock);
      check("midfill_reset_rom_valid", 32'(io_rom_valid), 0);
      check("midfill_reset_mem_rd", 32'(io_mem_rd), 0);
      step();
      reset = 1'b0;
      model_valid = 1'b0;
      exp_q.push_back(rom_byte(18'h00021));
      burst_q.push_back(BASE + AW'(18'h00020));
      model_valid = 1'b1;
      model_line  = 15'h0004;
      @(negedge clock);
      check("after_reset_mem_rd", 32'(io_mem_rd), 0);
      wait_valid(lat);
      check("refetch_accepts", 32'(accepts - acc0), 2);

      // Randomized traffic checked against the latency and byte model.
      for (int n = 0; n < 60; n++) begin
         s = $urandom_range(0, 3);
         if (s < 2)       a = {model_line, 3'($urandom_range(0, 7))};
         else if (s == 2) a = {15'(model_line + 15'd1), 3'($urandom_range(0, 7))};
         else             a = 18'($urandom);
         exp_hit = model_valid && (model_line == a[17:3]);
         mem_lat = $urandom_range(1, 4);
         mem_gap = $urandom_range(0, 2);
         s       = exp_hit ? 0 : $urandom_range(0, 3);
         stall_left = s;
         issue(a, lat);
         if (exp_hit) check("rand_hit_latency", 32'(lat), 0);
         else check("rand_miss_latency", 32'(lat), 32'(2 + s + mem_lat + 3 * (mem_gap + 1)));
      end

      repeat (3) step();
      check("exp_queue_drained", 32'(exp_q.size()), 0);
      check("burst_queue_drained", 32'(burst_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
